// File: rtl/io_pkg.sv
// Shared definitions for the IO feeder receiver.
// Holds the handshake FSM states, the command encoding and default sizes.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam logic CMD_LOAD    = 1'b1;
    localparam logic CMD_PROCESS = 1'b0;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 64;

endpackage

// File: rtl/io_word_buffer.sv
// On-chip word store for loaded feeder data.
// It has one synchronous write port and one registered read port; reading the address being written returns the old word.
module io_word_buffer
    import io_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [DATA_W-1:0] rdData_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdData_q;

    // The storage array has no reset, so its contents survive a receiver reset.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdData_q <= '0;
        end else begin
            rdData_q <= mem[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/io_receiver.sv
// Accelerator-side end of the IO feeder protocol.
// It buffers loaded words, starts the solver core on a process command and acknowledges the feeder through done.
module io_receiver
    import io_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              intrpt,
    input  logic              cmd,
    input  logic [DATA_W-1:0] dataBus,
    output logic              done,
    output logic              proc_start,
    input  logic              proc_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_WORD   = (ADDR_W + 1)'(1);

    state_e          state_q;
    logic            done_q;
    logic            procStart_q;
    logic            overflow_q;
    logic            overflow_d;
    logic [ADDR_W:0] wordCount_q;
    logic [ADDR_W:0] wordCount_d;
    logic            loadReq;
    logic            bufferFull;
    logic            wrEn;

    assign loadReq    = (state_q == IDLE) && intrpt && (cmd == CMD_LOAD);
    assign bufferFull = (wordCount_q >= FULL_COUNT);
    assign wrEn       = loadReq && !bufferFull && !reset;

    // A load into a full buffer is dropped and only leaves the sticky overflow mark.
    always_comb begin
        wordCount_d = wordCount_q;
        overflow_d  = overflow_q;
        if (loadReq) begin
            if (bufferFull) begin
                overflow_d = 1'b1;
            end else begin
                wordCount_d = wordCount_q + ONE_WORD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            procStart_q <= 1'b0;
            wordCount_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            procStart_q <= 1'b0;
            wordCount_q <= wordCount_d;
            overflow_q  <= overflow_d;
            case (state_q)
                IDLE: begin
                    if (intrpt && cmd == CMD_LOAD) begin
                        done_q  <= 1'b1;
                        state_q <= ACK;
                    end else if (intrpt && cmd == CMD_PROCESS) begin
                        procStart_q <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                ACK: begin
                    if (!intrpt) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    // A proc_done seen alongside the start pulse belongs to the previous job.
                    done_q <= 1'b0;
                    if (proc_done && !procStart_q) begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    if (!intrpt) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    io_word_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) wordBuffer (
        .clk      (clk),
        .reset    (reset),
        .wrEn_i   (wrEn),
        .wrAddr_i (wordCount_q[ADDR_W-1:0]),
        .wrData_i (dataBus),
        .rdAddr_i (rd_addr),
        .rdData_o (rd_data)
    );

    assign done       = done_q;
    assign proc_start = procStart_q;
    assign word_count = wordCount_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/io_receiver.md
Name: io_receiver

Overview:
- Accelerator-side end of the IO feeder protocol.
- The feeder drives intrpt, cmd and dataBus; this block answers with done.
- On each load command it stores one 32-bit word into an on-chip word buffer.
- On the process command it starts the solver core, waits for the core to finish, then reports completion to the feeder by holding done high.

Parameters:
- DATA_W, 32, width of dataBus and of each buffer word.
- DEPTH, 64, number of buffer words.
- ADDR_W, $clog2(DEPTH), width of buffer addresses and of the write pointer.

Ports:
- clk  in  1  single system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- intrpt  in  1  command-valid from the feeder.
- cmd  in  1  command from the feeder: 1 = load, 0 = process; valid only while intrpt=1.
- dataBus  in  DATA_W  word to load; sampled when a load is accepted.
- done  out  1  acknowledge to the feeder.
- proc_start  out  1  one-cycle pulse that starts the solver core.
- proc_done  in  1  solver core finished; level or pulse.
- rd_addr  in  ADDR_W  solver read address into the buffer.
- rd_data  out  DATA_W  buffer word at rd_addr, registered.
- word_count  out  ADDR_W+1  number of words stored since reset.
- overflow  out  1  sticky flag: a load arrived while the buffer was full.

Behaviour:
- Reset (synchronous, active-high; wins over everything, including mid-handshake or mid-process):
  - state=IDLE; done=0, proc_start=0, word_count=0, overflow=0, rd_data=0.
  - Buffer contents are not cleared.
- IDLE:
  - intrpt=0: stay in IDLE.
  - intrpt=1, cmd=1 (load):
    - if word_count<DEPTH: write dataBus to buf[word_count] and increment word_count;
    - else: drop the word and set overflow;
    - in both cases: done<=1, state<=ACK.
  - intrpt=1, cmd=0 (process): proc_start<=1 for exactly one cycle, state<=RUN.
  - cmd and dataBus are sampled on the same edge as intrpt.
- ACK:
  - done stays 1 while intrpt=1.
  - The first edge sampling intrpt=0 sets done<=0 and state<=IDLE.
  - Nothing is written while in ACK, so a word is never captured twice.
- Resulting load cadence with the feeder:
  - edge k: capture, done rises;
  - edge k+1: feeder drops intrpt and presents the next word;
  - edge k+2: done falls;
  - edge k+3: next capture.
  - That is 3 cycles per word.
- RUN:
  - done=0.
  - Wait for proc_done=1; then done<=1, state<=FIN.
  - proc_done sampled on the same edge as the proc_start pulse is ignored, so the earliest exit is one cycle after proc_start.
  - intrpt and cmd are ignored in RUN.
- FIN:
  - done is held 1; the feeder keeps intrpt=1, cmd=0.
  - On intrpt=0: done<=0, state<=IDLE, which allows a new load/process session.
  - word_count is kept; only reset clears it.
- Read port:
  - rd_data<=buf[rd_addr] every cycle (1-cycle latency, independent of state).
  - Read and write of the same address on the same edge returns the old word.
- word_count saturates at DEPTH. overflow clears only on reset.
- Boundary cases:
  - A process command with word_count=0 is legal; proc_start still pulses.
  - Unused state encodings go to IDLE.

Decomposition:
- Shared package io_pkg:
  - state enum IDLE/ACK/RUN/FIN;
  - CMD_LOAD=1'b1, CMD_PROCESS=1'b0;
  - default DATA_W.
  - The feeder-side bench model uses the same constants.
- One sub-module io_word_buffer:
  - DEPTH x DATA_W, one synchronous write port, one registered read port.
  - Parameters: DATA_W, DEPTH.

Test Plan:
1. Reset then idle:
   - Stimulus: reset=1 for 2 cycles, then intrpt=0 for 10 cycles.
   - Required: done=0, word_count=0, overflow=0, proc_start never asserted.
2. Single load:
   - Stimulus: intrpt=1, cmd=1, dataBus=32'hDEADBEEF; drop intrpt one cycle after done rises.
   - Required: done high for exactly 2 cycles, word_count=1; rd_addr=0 gives rd_data=32'hDEADBEEF the next cycle.
3. Back-to-back stream:
   - Stimulus: feeder model loads 5 words 1..5, then issues process; proc_done asserted 4 cycles after proc_start.
   - Required: loads 3 cycles apart, word_count=5, buf[0..4]=1..5; exactly one proc_start pulse; done rises one cycle after proc_done and stays 1.
4. Overflow:
   - Stimulus: DEPTH=4; load 6 words.
   - Required: every load acknowledged, word_count=4, overflow=1, buf[3] holds word 4 (not 5 or 6).
5. Reset mid-operation:
   - Stimulus (a): assert reset while in ACK with done=1. Required: done=0 next cycle, word_count=0.
   - Stimulus (b): assert reset while in RUN, then apply proc_done. Required: no done.
6. Session restart:
   - Stimulus: from FIN, drop intrpt, then load 32'h1.
   - Required: state returns to IDLE, new word written at address word_count (continuing count), done handshake identical to scenario 2.
